// File: rtl/rvfi_mem_pkg.sv
// -----------------------------------------------------------------------------
// rvfi_mem_pkg
// Shared types and helpers for the RVFI memory responder.
//   chan_state_e  : per-channel request state (IDLE, WAIT, RESP)
//   DB_CMD_MEM    : db__cmd_3a value that selects a real memory access
//   lat_cnt_w()   : latency counter width sized for the larger channel latency
// -----------------------------------------------------------------------------
package rvfi_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } chan_state_e;

  localparam int DB_CMD_MEM = 0;

  // Both channels share one counter width so the sub-module stays uniform.
  function automatic int lat_cnt_w(input int ib_lat, input int db_lat);
    int max_lat;
    max_lat = (ib_lat > db_lat) ? ib_lat : db_lat;
    return $clog2(max_lat) + 1;
  endfunction

endpackage

// File: rtl/rvfi_mem_chan.sv
// -----------------------------------------------------------------------------
// rvfi_mem_chan
// One request channel of the memory responder: accepts a request in IDLE,
// latches its payload, waits at least LAT cycles (and while stall is high),
// then spends exactly one cycle in RESP.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   en             : request strobe (only honoured in IDLE)
//   stall          : holds the channel in WAIT
//   pay            : request payload (address and, for db, data/lanes/cmd)
//   resp           : high during the single response cycle
//   pay_q_o        : payload latched at accept time
// -----------------------------------------------------------------------------
module rvfi_mem_chan
  import rvfi_mem_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int CNT_W = 1,
  parameter int PAY_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             stall,
  input  logic [PAY_W-1:0] pay,
  output logic             resp,
  output logic [PAY_W-1:0] pay_q_o
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LAT - 1);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PAY_W-1:0] pay_q, pay_d;

  // The move to RESP looks at the post-decrement count, so a request
  // accepted at edge t reaches RESP no earlier than cycle t+LAT.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pay_d   = pay_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          pay_d   = pay;
          count_d = LOAD_VAL;
          state_d = ((LOAD_VAL == '0) && !stall) ? RESP : WAIT;
        end
      end
      WAIT: begin
        count_d = (count_q != '0) ? (count_q - CNT_W'(1)) : '0;
        if ((count_d == '0) && !stall) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      pay_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pay_q   <= pay_d;
    end
  end

  assign resp    = (state_q == RESP);
  assign pay_q_o = pay_q;

endmodule

// File: rtl/rvfi_mem_responder.sv
// -----------------------------------------------------------------------------
// rvfi_mem_responder
// Memory/bus responder for harness wrappers around the core. Serves the
// instruction bus (ib, stage 0a -> 1a) and data bus (db, stage 3a -> 4a) from
// one internal word array, with programmable latency and external stalls.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   ib__en_0a / ib__addr_0a       : fetch request and word address
//   ib__valid_1a/data_1a/error_1a : fetch response (error = out of range)
//   db__en_3a / db__addr_3a       : data request and word address
//   db__write_data_3a/write_en_3a : store data and byte-lane enables
//   db__cmd_3a                    : 0 = memory access, else non-memory op
//   db__valid_4a/data_4a/error_4a : data response
//   ib_stall / db_stall           : hold each channel in WAIT
// -----------------------------------------------------------------------------
module rvfi_mem_responder
  import rvfi_mem_pkg::*;
#(
  parameter int ADDR_W    = 30,
  parameter int DEPTH     = 1024,
  parameter int IB_LAT    = 1,
  parameter int DB_LAT    = 1,
  parameter int DBC_W     = 4,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ib__en_0a,
  input  logic [ADDR_W-1:0] ib__addr_0a,
  output logic              ib__valid_1a,
  output logic [31:0]       ib__data_1a,
  output logic              ib__error_1a,
  input  logic              db__en_3a,
  input  logic [ADDR_W-1:0] db__addr_3a,
  input  logic [31:0]       db__write_data_3a,
  input  logic [3:0]        db__write_en_3a,
  input  logic [DBC_W-1:0]  db__cmd_3a,
  output logic              db__valid_4a,
  output logic [31:0]       db__data_4a,
  output logic              db__error_4a,
  input  logic              ib_stall,
  input  logic              db_stall
);

  localparam int CNT_W    = lat_cnt_w(IB_LAT, DB_LAT);
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DB_PAY_W = DBC_W + 4 + 32 + ADDR_W;

  // Contents come up cleared at time zero only; reset never touches them.
  logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx};

  logic                ib_resp;
  logic [ADDR_W-1:0]   ib_addr_q;
  logic                db_resp;
  logic [DB_PAY_W-1:0] db_pay_q;
  logic [ADDR_W-1:0]   db_addr_q;
  logic [31:0]         db_wdata_q;
  logic [3:0]          db_wen_q;
  logic [DBC_W-1:0]    db_cmd_q;
  logic                ib_in_range, db_in_range, db_is_mem, db_load, db_store;
  logic [IDX_W-1:0]    ib_idx, db_idx;

  // Extra leading zero keeps the compare correct when DEPTH == 2**ADDR_W.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W + 1)'(DEPTH);
  endfunction

  rvfi_mem_chan #(
    .LAT   (IB_LAT),
    .CNT_W (CNT_W),
    .PAY_W (ADDR_W)
  ) u_ib_chan (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ib__en_0a),
    .stall   (ib_stall),
    .pay     (ib__addr_0a),
    .resp    (ib_resp),
    .pay_q_o (ib_addr_q)
  );

  rvfi_mem_chan #(
    .LAT   (DB_LAT),
    .CNT_W (CNT_W),
    .PAY_W (DB_PAY_W)
  ) u_db_chan (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (db__en_3a),
    .stall   (db_stall),
    .pay     ({db__cmd_3a, db__write_en_3a, db__write_data_3a, db__addr_3a}),
    .resp    (db_resp),
    .pay_q_o (db_pay_q)
  );

  assign {db_cmd_q, db_wen_q, db_wdata_q, db_addr_q} = db_pay_q;

  assign ib_in_range = in_range(ib_addr_q);
  assign db_in_range = in_range(db_addr_q);
  assign ib_idx      = ib_addr_q[IDX_W-1:0];
  assign db_idx      = db_addr_q[IDX_W-1:0];
  assign db_is_mem   = (db_cmd_q == DBC_W'(DB_CMD_MEM));
  assign db_load     = db_resp && db_is_mem && (db_wen_q == 4'h0) && db_in_range;
  assign db_store    = db_resp && db_is_mem && (db_wen_q != 4'h0) && db_in_range;

  // Responses are combinational from the RESP state; every field is zero
  // outside it. The ib read sees the array before a same-cycle db store lands.
  always_comb begin
    ib__valid_1a = ib_resp;
    ib__error_1a = ib_resp && !ib_in_range;
    ib__data_1a  = (ib_resp && ib_in_range) ? mem[ib_idx] : 32'h0;
    db__valid_4a = db_resp;
    db__error_4a = db_resp && db_is_mem && !db_in_range;
    db__data_4a  = db_load ? mem[db_idx] : 32'h0;
  end

  // Byte-lane store commits at the end of the db RESP cycle; a reset during
  // WAIT or RESP drops the channel to IDLE so the store never fires.
  always_ff @(posedge clk) begin
    if (db_store) begin
      for (int i = 0; i < 4; i++) begin
        if (db_wen_q[i]) begin
          mem[db_idx][8*i +: 8] <= db_wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_rvfi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_rvfi_mem_responder
// Self-checking bench for rvfi_mem_responder (IB_LAT=1, DB_LAT=3). A
// transaction-level reference model predicts each channel's response cycle
// from "accepted at least LAT cycles ago and not stalled" and keeps its own
// copy of the memory. Directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_rvfi_mem_responder;

  localparam int ADDR_W = 30;
  localparam int DEPTH  = 1024;
  localparam int IB_LAT = 1;
  localparam int DB_LAT = 3;
  localparam int DBC_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ib__en_0a;
  logic [ADDR_W-1:0] ib__addr_0a;
  logic              ib__valid_1a;
  logic [31:0]       ib__data_1a;
  logic              ib__error_1a;
  logic              db__en_3a;
  logic [ADDR_W-1:0] db__addr_3a;
  logic [31:0]       db__write_data_3a;
  logic [3:0]        db__write_en_3a;
  logic [DBC_W-1:0]  db__cmd_3a;
  logic              db__valid_4a;
  logic [31:0]       db__data_4a;
  logic              db__error_4a;
  logic              ib_stall;
  logic              db_stall;

  rvfi_mem_responder #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .IB_LAT    (IB_LAT),
    .DB_LAT    (DB_LAT),
    .DBC_W     (DBC_W),
    .INIT_ZERO (1)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ib__en_0a         (ib__en_0a),
    .ib__addr_0a       (ib__addr_0a),
    .ib__valid_1a      (ib__valid_1a),
    .ib__data_1a       (ib__data_1a),
    .ib__error_1a      (ib__error_1a),
    .db__en_3a         (db__en_3a),
    .db__addr_3a       (db__addr_3a),
    .db__write_data_3a (db__write_data_3a),
    .db__write_en_3a   (db__write_en_3a),
    .db__cmd_3a        (db__cmd_3a),
    .db__valid_4a      (db__valid_4a),
    .db__data_4a       (db__data_4a),
    .db__error_4a      (db__error_4a),
    .ib_stall          (ib_stall),
    .db_stall          (db_stall)
  );

  always #5 clk = ~clk;

  // Reference model: one record per outstanding request.
  typedef struct {
    bit          waiting;
    bit          resp;
    int          elapsed;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
    logic [3:0]  cmd;
  } req_model_t;

  req_model_t  m_ib, m_db;
  logic [31:0] ref_mem [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Random requester state (held until its response is seen).
  bit          ib_cur_en, db_cur_en;
  logic [29:0] ib_cur_addr, db_cur_addr;
  logic [31:0] db_cur_wd;
  logic [3:0]  db_cur_wen, db_cur_cmd;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit inRange(input logic [29:0] a);
    return a < 30'(DEPTH);
  endfunction

  // Advances one request record across a clock edge.
  function automatic req_model_t advance(input req_model_t m, input bit en, input bit stall,
                                         input int lat, input logic [29:0] a,
                                         input logic [31:0] wd, input logic [3:0] we,
                                         input logic [3:0] cmd);
    req_model_t r;
    r = m;
    if (r.resp) begin
      r.resp = 0;
    end else if (r.waiting) begin
      r.elapsed++;
      if (r.elapsed >= lat && !stall) begin
        r.waiting = 0;
        r.resp    = 1;
      end
    end else if (en) begin
      r.addr    = a;
      r.wdata   = wd;
      r.wen     = we;
      r.cmd     = cmd;
      r.elapsed = 1;
      if (r.elapsed >= lat && !stall) r.resp = 1;
      else r.waiting = 1;
    end
    return r;
  endfunction

  function automatic req_model_t idleReq();
    req_model_t r;
    r.waiting = 0;
    r.resp    = 0;
    r.elapsed = 0;
    r.addr    = '0;
    r.wdata   = '0;
    r.wen     = '0;
    r.cmd     = '0;
    return r;
  endfunction

  // Compares all six response outputs with what the model says this cycle.
  task automatic checkAll();
    logic [31:0] e_ib_data, e_db_data;
    bit          e_ib_err, e_db_err, db_mem;
    e_ib_err  = m_ib.resp && !inRange(m_ib.addr);
    e_ib_data = (m_ib.resp && inRange(m_ib.addr)) ? ref_mem[m_ib.addr[9:0]] : 32'h0;
    db_mem    = (m_db.cmd == 4'h0);
    e_db_err  = m_db.resp && db_mem && !inRange(m_db.addr);
    e_db_data = (m_db.resp && db_mem && m_db.wen == 4'h0 && inRange(m_db.addr))
                ? ref_mem[m_db.addr[9:0]] : 32'h0;
    checkOutput("ib_valid", 32'(ib__valid_1a), 32'(m_ib.resp));
    checkOutput("ib_error", 32'(ib__error_1a), 32'(e_ib_err));
    checkOutput("ib_data",  ib__data_1a,       e_ib_data);
    checkOutput("db_valid", 32'(db__valid_4a), 32'(m_db.resp));
    checkOutput("db_error", 32'(db__error_4a), 32'(e_db_err));
    checkOutput("db_data",  db__data_4a,       e_db_data);
  endtask

  // One clock cycle: check outputs, drive inputs at the falling edge, then
  // advance the model across the rising edge. Returns at posedge + 1.
  task automatic applyStimulus(input bit ie, input logic [29:0] ia, input bit is,
                               input bit de, input logic [29:0] da, input logic [31:0] dw,
                               input logic [3:0] dwe, input logic [3:0] dc, input bit ds);
    @(negedge clk);
    checkAll();
    ib__en_0a         = ie;
    ib__addr_0a       = ia;
    ib_stall          = is;
    db__en_3a         = de;
    db__addr_3a       = da;
    db__write_data_3a = dw;
    db__write_en_3a   = dwe;
    db__cmd_3a        = dc;
    db_stall          = ds;
    @(posedge clk);
    #1;
    if (m_db.resp && m_db.cmd == 4'h0 && m_db.wen != 4'h0 && inRange(m_db.addr)) begin
      for (int i = 0; i < 4; i++) begin
        if (m_db.wen[i]) ref_mem[m_db.addr[9:0]][8*i +: 8] = m_db.wdata[8*i +: 8];
      end
    end
    m_ib = advance(m_ib, ie, is, IB_LAT, ia, 32'h0, 4'h0, 4'h0);
    m_db = advance(m_db, de, ds, DB_LAT, da, dw, dwe, dc);
  endtask

  task automatic idleCycle();
    applyStimulus(0, '0, 0, 0, '0, 32'h0, 4'h0, 4'h0, 0);
  endtask

  // Holds a db request until the model predicts its response cycle.
  task automatic dbTxn(input logic [29:0] a, input logic [31:0] wd, input logic [3:0] we,
                       input logic [3:0] cmd);
    int guard;
    guard = 0;
    do begin
      applyStimulus(0, '0, 0, 1, a, wd, we, cmd, 0);
      guard++;
    end while (!m_db.resp && guard < 50);
    checkOutput("db_txn_valid", 32'(db__valid_4a), 32'd1);
  endtask

  task automatic ibTxn(input logic [29:0] a);
    int guard;
    guard = 0;
    do begin
      applyStimulus(1, a, 0, 0, '0, 32'h0, 4'h0, 4'h0, 0);
      guard++;
    end while (!m_ib.resp && guard < 50);
    checkOutput("ib_txn_valid", 32'(ib__valid_1a), 32'd1);
  endtask

  // Asynchronous reset away from any clock edge; outputs must clear at once.
  task automatic asyncReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ib_valid", 32'(ib__valid_1a), 32'd0);
    checkOutput("rst_ib_data",  ib__data_1a,       32'd0);
    checkOutput("rst_ib_error", 32'(ib__error_1a), 32'd0);
    checkOutput("rst_db_valid", 32'(db__valid_4a), 32'd0);
    checkOutput("rst_db_data",  db__data_4a,       32'd0);
    checkOutput("rst_db_error", 32'(db__error_4a), 32'd0);
    m_ib      = idleReq();
    m_db      = idleReq();
    ib_cur_en = 0;
    db_cur_en = 0;
    @(negedge clk);
    ib__en_0a = 1'b0;
    db__en_3a = 1'b0;
    ib_stall  = 1'b0;
    db_stall  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [29:0] randAddr();
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 12) return 30'($urandom_range(0, 15));
    else if (r < 14) return 30'(1020 + $urandom_range(0, 7));
    else return 30'h3FFF_FFFF - 30'($urandom_range(0, 3));
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    m_ib              = idleReq();
    m_db              = idleReq();
    ib_cur_en         = 0;
    db_cur_en         = 0;
    ib_cur_addr       = '0;
    db_cur_addr       = '0;
    db_cur_wd         = '0;
    db_cur_wen        = '0;
    db_cur_cmd        = '0;
    rst_n             = 1'b0;
    ib__en_0a         = 1'b0;
    ib__addr_0a       = '0;
    ib_stall          = 1'b0;
    db__en_3a         = 1'b0;
    db__addr_3a       = '0;
    db__write_data_3a = '0;
    db__write_en_3a   = '0;
    db__cmd_3a        = '0;
    db_stall          = 1'b0;

    // Reset state.
    #3;
    checkOutput("reset_ib_valid", 32'(ib__valid_1a), 32'd0);
    checkOutput("reset_db_valid", 32'(db__valid_4a), 32'd0);
    checkOutput("reset_db_data",  db__data_4a,       32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Preload word 5, then fetch it with IB_LAT=1: valid exactly at t+1.
    dbTxn(30'd5, 32'hDEAD_BEEF, 4'hF, 4'h0);
    applyStimulus(1, 30'd5, 0, 0, '0, 32'h0, 4'h0, 4'h0, 0);
    checkOutput("ib_lat1_valid", 32'(ib__valid_1a), 32'd1);
    checkOutput("ib_lat1_data",  ib__data_1a,       32'hDEAD_BEEF);
    idleCycle();
    checkOutput("ib_lat1_once", 32'(ib__valid_1a), 32'd0);

    // DB_LAT=3 with stall held through edge t+4: first valid in cycle t+6.
    idleCycle();
    applyStimulus(0, '0, 0, 1, 30'd5, 32'h0, 4'h0, 4'h0, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, '0, 0, 1, 30'd5, 32'h0, 4'h0, 4'h0, 1);
      checkOutput("db_stall_hold", 32'(db__valid_4a), 32'd0);
    end
    applyStimulus(0, '0, 0, 1, 30'd5, 32'h0, 4'h0, 4'h0, 0);
    checkOutput("db_stall_valid", 32'(db__valid_4a), 32'd1);
    checkOutput("db_stall_data",  db__data_4a,       32'hDEAD_BEEF);
    idleCycle();
    checkOutput("db_stall_once", 32'(db__valid_4a), 32'd0);

    // Byte-lane store merge.
    dbTxn(30'd8, 32'hAABB_CCDD, 4'hF, 4'h0);
    dbTxn(30'd8, 32'h1122_3344, 4'b0101, 4'h0);
    checkOutput("store_data_zero", db__data_4a, 32'd0);
    dbTxn(30'd8, 32'h0, 4'h0, 4'h0);
    checkOutput("lane_merge", db__data_4a, 32'hAA22_CC44);

    // Non-memory command: no access, zero data, no error.
    dbTxn(30'd8, 32'hFFFF_FFFF, 4'hF, 4'h5);
    checkOutput("cmd_data",  db__data_4a,       32'd0);
    checkOutput("cmd_error", 32'(db__error_4a), 32'd0);
    dbTxn(30'd8, 32'h0, 4'h0, 4'h0);
    checkOutput("cmd_no_write", db__data_4a, 32'hAA22_CC44);

    // Out-of-range store reports an error and leaves word 0 alone.
    dbTxn(30'd1024, 32'hFFFF_FFFF, 4'hF, 4'h0);
    checkOutput("oor_error", 32'(db__error_4a), 32'd1);
    checkOutput("oor_data",  db__data_4a,       32'd0);
    dbTxn(30'd0, 32'h0, 4'h0, 4'h0);
    checkOutput("oor_word0", db__data_4a, 32'd0);

    // Collision on word 3: ib and db store respond in the same cycle.
    idleCycle();
    applyStimulus(0, '0, 0, 1, 30'd3, 32'hFFFF_FFFF, 4'hF, 4'h0, 0);
    applyStimulus(0, '0, 0, 1, 30'd3, 32'hFFFF_FFFF, 4'hF, 4'h0, 0);
    applyStimulus(1, 30'd3, 0, 1, 30'd3, 32'hFFFF_FFFF, 4'hF, 4'h0, 0);
    checkOutput("coll_db_valid", 32'(db__valid_4a), 32'd1);
    checkOutput("coll_ib_valid", 32'(ib__valid_1a), 32'd1);
    checkOutput("coll_ib_old",   ib__data_1a,       32'h0);
    idleCycle();
    ibTxn(30'd3);
    checkOutput("coll_ib_new", ib__data_1a, 32'hFFFF_FFFF);

    // Reset mid-WAIT: pending store is dropped, no stale response later.
    idleCycle();
    applyStimulus(0, '0, 0, 1, 30'd9, 32'h1234_5678, 4'hF, 4'h0, 1);
    applyStimulus(0, '0, 0, 1, 30'd9, 32'h1234_5678, 4'hF, 4'h0, 1);
    asyncReset();
    repeat (5) idleCycle();
    dbTxn(30'd9, 32'h0, 4'h0, 4'h0);
    checkOutput("rst_wait_nowrite", db__data_4a, 32'd0);

    // Reset mid-RESP on both channels.
    idleCycle();
    dbTxn(30'd10, 32'h5555_AAAA, 4'hF, 4'h0);
    asyncReset();
    idleCycle();
    dbTxn(30'd10, 32'h0, 4'h0, 4'h0);
    checkOutput("rst_resp_nowrite", db__data_4a, 32'd0);
    ibTxn(30'd5);
    asyncReset();
    idleCycle();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      if (!ib_cur_en || m_ib.resp) begin
        ib_cur_en   = ($urandom_range(0, 9) < 6);
        ib_cur_addr = randAddr();
      end
      if (!db_cur_en || m_db.resp) begin
        db_cur_en   = ($urandom_range(0, 9) < 6);
        db_cur_addr = randAddr();
        db_cur_wd   = $urandom;
        db_cur_wen  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        db_cur_cmd  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      end
      applyStimulus(ib_cur_en, ib_cur_addr, ($urandom_range(0, 3) == 0),
                    db_cur_en, db_cur_addr, db_cur_wd, db_cur_wen, db_cur_cmd,
                    ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
